// File: rtl/div_unit.sv
// Iterative 32-bit divider: restoring shift-subtract, one quotient bit per clock.
// Signed mode divides magnitudes and corrects signs at the end (truncation toward zero).
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; operands captured on the start edge
// RUN    | 32 shift-subtract steps, counter 0..31
// FINISH | sign correction, result registers loaded, done pulsed
module div_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [4:0]  cnt;
  logic [31:0] dvd_q;     // dividend shifts out of the top, quotient bits shift in
  logic [31:0] dvs;       // divisor magnitude
  logic [31:0] prem;      // partial remainder, always below the divisor
  logic [31:0] a_orig;    // uncorrected dividend, returned as remainder on divide-by-zero
  logic        sign_q;
  logic        sign_r;
  logic        zero_div;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] prem_sh;
  logic [32:0] diff;

  // Operand magnitudes for the capture edge
  always_comb begin
    a_mag = (signed_op && A[31]) ? (~A + 32'd1) : A;
    b_mag = (signed_op && B[31]) ? (~B + 32'd1) : B;
  end

  // One restoring step: the 33-bit shifted remainder minus the divisor; bit 32 is the borrow
  always_comb begin
    prem_sh = {prem, dvd_q[31]};
    diff    = prem_sh - {1'b0, dvs};
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (B == 32'd0) ? FINISH : RUN;
      RUN:     if (cnt == 5'd31) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath, step counter and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt         <= 5'd0;
      dvd_q       <= 32'd0;
      dvs         <= 32'd0;
      prem        <= 32'd0;
      a_orig      <= 32'd0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      zero_div    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= 32'd0;
      remainder   <= 32'd0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd_q    <= a_mag;
            dvs      <= b_mag;
            prem     <= 32'd0;
            a_orig   <= A;
            cnt      <= 5'd0;
            sign_q   <= signed_op & (A[31] ^ B[31]);
            sign_r   <= signed_op & A[31];
            zero_div <= (B == 32'd0);
            busy     <= 1'b1;
          end
        end
        RUN: begin
          cnt <= cnt + 5'd1;
          if (!diff[32]) begin
            prem  <= diff[31:0];
            dvd_q <= {dvd_q[30:0], 1'b1};
          end else begin
            prem  <= prem_sh[31:0];
            dvd_q <= {dvd_q[30:0], 1'b0};
          end
        end
        FINISH: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (zero_div) begin
            quotient    <= 32'hFFFF_FFFF;
            remainder   <= a_orig;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= sign_q ? (~dvd_q + 32'd1) : dvd_q;
            remainder   <= sign_r ? (~prem + 32'd1) : prem;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corners, protocol cases and random operands
// compared against a plain-arithmetic reference.
module tb_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        signed_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int errors = 0;
  int checks = 0;

  div_unit dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .signed_op   (signed_op),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: 64-bit arithmetic so that -2^31 / -1 cannot overflow
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb, lq, lr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else begin
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[31:0];
      r  = lr[31:0];
      z  = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one operation from IDLE; scramble operands after capture, optionally poke start mid-run
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input bit poke);
    logic [31:0] eq, er;
    logic        ez;
    int          cyc;
    int          lat;
    bit          busy_bad;
    ref_div(a, b, s, eq, er, ez);
    lat = (b == 32'd0) ? 1 : 33;
    A = a; B = b; signed_op = s; start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_set", {31'd0, busy}, 32'd1);
    A = $urandom; B = $urandom; signed_op = 1'($urandom_range(0, 1));
    cyc = 0;
    busy_bad = 1'b0;
    while (cyc < 40) begin
      if (poke && cyc == 4) start = 1'b1;
      tick();
      cyc++;
      start = 1'b0;
      if (done) break;
      if (!busy) busy_bad = 1'b1;
    end
    check("latency", cyc, lat);
    check("busy_during", {31'd0, busy_bad}, 32'd0);
    check("busy_clear", {31'd0, busy}, 32'd0);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_by_zero", {31'd0, div_by_zero}, {31'd0, ez});
    repeat (3) tick();
    check("done_pulse", {31'd0, done}, 32'd0);
    check("no_queue", {31'd0, busy}, 32'd0);
    check("hold_q", quotient, eq);
    check("hold_r", remainder, er);
  endtask

  initial begin
    logic [31:0] ra, rb, eq, er;
    logic        rs, ez;
    int          cyc;
    int          ndone;
    int          tdone[3];
    bit          saw_done;

    reset = 1'b1; start = 1'b0; signed_op = 1'b0; A = 32'd0; B = 32'd0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Directed cases
    run_op(32'd100, 32'd7, 1'b0, 1'b1);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1);
    run_op(32'h1234_5678, 32'd0, 1'b0, 1'b0);
    run_op(32'h8765_4321, 32'd0, 1'b1, 1'b0);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op(32'd5, 32'd9, 1'b0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Reset ten edges into an operation
    A = 32'd1000; B = 32'd3; signed_op = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_q", quotient, 32'd0);
    check("abort_r", remainder, 32'd0);
    check("abort_dbz", {31'd0, div_by_zero}, 32'd0);
    saw_done = 1'b0;
    repeat (3) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    reset = 1'b0;
    repeat (40) begin
      tick();
      if (done || busy) saw_done = 1'b1;
    end
    check("abort_no_done", {31'd0, saw_done}, 32'd0);
    run_op(32'd1000, 32'd3, 1'b0, 1'b0);

    // Random operands
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'($urandom_range(1, 255));
        1: rb = (i % 6 == 0) ? 32'd0 : $urandom;
        2: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 1000));
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs, 1'($urandom_range(0, 1)));
    end

    // start held high: done pulses every 34 cycles
    A = 32'hDEAD_BEEF; B = 32'd12345; signed_op = 1'b1;
    ref_div(A, B, 1'b1, eq, er, ez);
    start = 1'b1;
    cyc = 0;
    ndone = 0;
    while (cyc < 150 && ndone < 3) begin
      tick();
      cyc++;
      if (done) begin
        tdone[ndone] = cyc;
        ndone++;
        check("b2b_q", quotient, eq);
        check("b2b_r", remainder, er);
        if (ndone == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_count", ndone, 32'd3);
    if (ndone == 3) begin
      check("b2b_period1", tdone[1] - tdone[0], 32'd34);
      check("b2b_period2", tdone[2] - tdone[1], 32'd34);
    end
    repeat (2) tick();
    check("b2b_idle", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
